fp_comp_sched: RTL and testbench

- Round-robin scheduler that shares one FP32 comparator datapath (fixed-latency, registered less/eq/great/inv outputs) among NREQ requesters.
- Accepts compare requests via per-requester valid/ready and issues at most one per cycle to the comparator.
- Tracks in-flight operations in a tag pipeline and routes each result back to its originator.
- Provides enable/drain control and a saturating invalid-result counter for the FPU status logic.

---
 rtl/fp_comp_sched_if.sv | 25 ++
 rtl/fp_comp_sched.sv | 128 ++++++++++++
 tb/tb_fp_comp_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_comp_sched_if.sv
// Requester-side bus of the shared FP32 comparator scheduler.
// The master side is the requester pool; the slave side is the scheduler.
interface fp_comp_sched_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_less;
    logic               rsp_eq;
    logic               rsp_great;
    logic               rsp_inv;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_less, rsp_eq, rsp_great, rsp_inv
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_less, rsp_eq, rsp_great, rsp_inv
    );
endinterface

// File: rtl/fp_comp_sched.sv
// Round-robin scheduler sharing one fixed-latency FP32 comparator among NREQ requesters.
// Issued operations are tracked by a one-hot tag pipeline so each result returns to its owner.
module fp_comp_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned CMP_LAT = 1,
    parameter int unsigned IDW     = 2,
    parameter int unsigned CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clr_cnt,
    fp_comp_sched_if.slave  bus,
    output logic [31:0]     cmp_a,
    output logic [31:0]     cmp_b,
    input  logic            cmp_less,
    input  logic            cmp_eq,
    input  logic            cmp_great,
    input  logic            cmp_inv,
    output logic            busy,
    output logic            idle,
    output logic [CNTW-1:0] inv_cnt
);

    typedef enum logic [1:0] {StHalt, StRun, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [IDW-1:0]              rr_ptr_q;
    logic [CMP_LAT-1:0]          stage_v_q;
    logic [CMP_LAT-1:0][NREQ-1:0] stage_id_q;
    logic [CNTW-1:0]             inv_cnt_q;

    logic                        grant_found;
    logic [IDW-1:0]              grant_id;
    logic [IDW-1:0]              idx;
    logic [NREQ-1:0]             grant_oh;
    logic                        transfer;
    logic [CMP_LAT-1:0]          early_v;
    logic                        last_v;

    // Round-robin search starting at rr_ptr; pointer arithmetic wraps since NREQ = 2**IDW.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = rr_ptr_q + IDW'(k);
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
        if (grant_found) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    // Grant, operand mux and response routing; everything is zero when not qualified.
    always_comb begin
        transfer      = (state_q == StRun) && grant_found;
        bus.req_ready = transfer ? grant_oh : '0;
        cmp_a         = transfer ? bus.req_a[{grant_id, 5'd0} +: 32] : '0;
        cmp_b         = transfer ? bus.req_b[{grant_id, 5'd0} +: 32] : '0;
        last_v        = stage_v_q[CMP_LAT-1];
        bus.rsp_valid = last_v ? stage_id_q[CMP_LAT-1] : '0;
        bus.rsp_less  = cmp_less  & last_v;
        bus.rsp_eq    = cmp_eq    & last_v;
        bus.rsp_great = cmp_great & last_v;
        bus.rsp_inv   = cmp_inv   & last_v;
        busy          = |stage_v_q;
        idle          = (state_q == StHalt);
        inv_cnt       = inv_cnt_q;
        // Tags not in the last stage: if none, the pipeline is empty after this edge.
        early_v          = stage_v_q;
        early_v[CMP_LAT-1] = 1'b0;
    end

    // Next-state logic for the enable/drain controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt:  if (enable) state_d = StRun;
            StRun:   if (!enable) state_d = StDrain;
            StDrain: begin
                if (enable) begin
                    state_d = StRun;
                end else if (early_v == '0) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // State, round-robin pointer and tag pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StHalt;
            rr_ptr_q   <= '0;
            stage_v_q  <= '0;
            stage_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                rr_ptr_q <= grant_id + 1'b1;
            end
            stage_v_q[0]  <= transfer;
            stage_id_q[0] <= transfer ? grant_oh : '0;
            for (int unsigned s = 1; s < CMP_LAT; s++) begin
                stage_v_q[s]  <= stage_v_q[s-1];
                stage_id_q[s] <= stage_id_q[s-1];
            end
        end
    end

    // Saturating invalid-result counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_cnt_q <= '0;
        end else if (clr_cnt) begin
            inv_cnt_q <= '0;
        end else if (bus.rsp_inv && (inv_cnt_q != '1)) begin
            inv_cnt_q <= inv_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_comp_sched.sv
// Directed bench for fp_comp_sched: one instance with CMP_LAT=1/CNTW=2, one with CMP_LAT=3.
module tb_fp_comp_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // {less, eq, great, inv}
    function automatic logic [3:0] fp_cmp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        if (((a[30:23] == 8'hff) && (a[22:0] != 0)) || ((b[30:23] == 8'hff) && (b[22:0] != 0)))
            return 4'b0001;
        if ((a[30:0] == 0) && (b[30:0] == 0))
            return 4'b0100;
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        if (ka < kb) return 4'b1000;
        if (ka == kb) return 4'b0100;
        return 4'b0010;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance 1: CMP_LAT=1, CNTW=2
    fp_comp_sched_if #(.NREQ(4)) bus1 ();
    logic        en1 = 1'b0, clr1 = 1'b0;
    logic [31:0] cmp_a1, cmp_b1;
    logic [3:0]  res1 = 4'b0;
    logic        busy1, idle1;
    logic [1:0]  cnt1;

    always @(posedge clk) res1 <= fp_cmp(cmp_a1, cmp_b1);

    fp_comp_sched #(.NREQ(4), .CMP_LAT(1), .IDW(2), .CNTW(2)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en1), .clr_cnt(clr1), .bus(bus1),
        .cmp_a(cmp_a1), .cmp_b(cmp_b1),
        .cmp_less(res1[3]), .cmp_eq(res1[2]), .cmp_great(res1[1]), .cmp_inv(res1[0]),
        .busy(busy1), .idle(idle1), .inv_cnt(cnt1)
    );

    // Instance 3: CMP_LAT=3, CNTW=8
    fp_comp_sched_if #(.NREQ(4)) bus3 ();
    logic        en3 = 1'b0, clr3 = 1'b0;
    logic [31:0] cmp_a3, cmp_b3;
    logic [3:0]  p3_0 = 4'b0, p3_1 = 4'b0, res3 = 4'b0;
    logic        busy3, idle3;
    logic [7:0]  cnt3;

    always @(posedge clk) begin
        p3_0 <= fp_cmp(cmp_a3, cmp_b3);
        p3_1 <= p3_0;
        res3 <= p3_1;
    end

    fp_comp_sched #(.NREQ(4), .CMP_LAT(3), .IDW(2), .CNTW(8)) u_dut3 (
        .clk(clk), .rst(rst), .enable(en3), .clr_cnt(clr3), .bus(bus3),
        .cmp_a(cmp_a3), .cmp_b(cmp_b3),
        .cmp_less(res3[3]), .cmp_eq(res3[2]), .cmp_great(res3[1]), .cmp_inv(res3[0]),
        .busy(busy3), .idle(idle3), .inv_cnt(cnt3)
    );

    logic [3:0] drain_exp [3];

    initial begin
        bus1.req_valid = '0;
        bus1.req_a = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
        bus1.req_b = {4{32'h4000_0000}};
        bus3.req_valid = '0;
        bus3.req_a = {32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
        bus3.req_b = {4{32'h4000_0000}};
        drain_exp[0] = 4'b1000;
        drain_exp[1] = 4'b0001;
        drain_exp[2] = 4'b0010;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_idle", idle1, 1);
        check("rst_busy", busy1, 0);
        check("rst_ready", bus1.req_ready, 0);
        check("rst_rsp", bus1.rsp_valid, 0);
        check("rst_cmp_a", cmp_a1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_idle3", idle3, 1);
        @(negedge clk);
        rst = 1'b1;

        // Round robin with all requesters valid
        @(negedge clk);
        en1 = 1'b1;
        bus1.req_valid = 4'b1111;
        #1;
        check("halt_ready", bus1.req_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("rr_grant", bus1.req_ready, 64'(4'b0001 << (i % 4)));
            check("rr_cmp_a", cmp_a1, 64'(32'h4000_0000 + (i % 4)));
            check("rr_idle", idle1, 0);
            if (i > 0) begin
                check("rr_rsp", bus1.rsp_valid, 64'(4'b0001 << ((i - 1) % 4)));
                check("rr_eq", bus1.rsp_eq, ((i - 1) % 4) == 0);
                check("rr_great", bus1.rsp_great, ((i - 1) % 4) != 0);
            end
        end

        // Pointer at 3 with only requester 1 valid
        @(negedge clk);
        bus1.req_valid = 4'b0100;
        #1;
        check("rsp_last", bus1.rsp_valid, 4'b0001);
        check("g2_ready", bus1.req_ready, 4'b0100);
        @(negedge clk);
        bus1.req_valid = 4'b0010;
        #1;
        check("ptr3_ready", bus1.req_ready, 4'b0010);
        check("g2_rsp", bus1.rsp_valid, 4'b0100);
        @(negedge clk);
        bus1.req_valid = 4'b1111;
        #1;
        check("ptr2_ready", bus1.req_ready, 4'b0100);

        // Invalid-result counter saturation and clear priority
        @(negedge clk);
        bus1.req_valid = 4'b0001;
        bus1.req_a[31:0] = 32'h7FC0_0000;
        #1;
        check("inv_grant", bus1.req_ready, 4'b0001);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) begin
                bus1.req_valid = 4'b0000;
                clr1 = 1'b1;
            end
            #1;
            check("inv_rsp", bus1.rsp_valid, 4'b0001);
            check("inv_flag", bus1.rsp_inv, 1);
            check("inv_cnt", cnt1, (k - 1 > 3) ? 3 : k - 1);
        end
        @(negedge clk);
        clr1 = 1'b0;
        #1;
        check("inv_clr", cnt1, 0);
        check("inv_norsp", bus1.rsp_valid, 0);

        // Single-cycle enable low pulse gives exactly one idle grant slot
        @(negedge clk);
        bus1.req_valid = 4'b1111;
        en1 = 1'b0;
        #1;
        check("pulse_run", bus1.req_ready, 4'b0010);
        @(negedge clk);
        en1 = 1'b1;
        #1;
        check("pulse_gap", bus1.req_ready, 4'b0000);
        @(negedge clk);
        #1;
        check("pulse_back", bus1.req_ready, 4'b0100);
        @(negedge clk);
        bus1.req_valid = 4'b0000;
        en1 = 1'b0;

        // CMP_LAT=3: requester 2 compares 1.0 < 2.0
        @(negedge clk);
        en3 = 1'b1;
        @(negedge clk);
        bus3.req_valid = 4'b0100;
        #1;
        check("l3_ready", bus3.req_ready, 4'b0100);
        check("l3_cmp_a", cmp_a3, 32'h3F80_0000);
        @(negedge clk);
        bus3.req_valid = 4'b0000;
        #1;
        check("l3_rsp_t1", bus3.rsp_valid, 0);
        check("l3_busy", busy3, 1);
        @(negedge clk);
        #1;
        check("l3_rsp_t2", bus3.rsp_valid, 0);
        @(negedge clk);
        #1;
        check("l3_rsp_t3", bus3.rsp_valid, 4'b0100);
        check("l3_less", bus3.rsp_less, 1);
        check("l3_eq", bus3.rsp_eq, 0);

        // Three ops then enable dropped: drain, then HALT the cycle after the last response
        @(negedge clk);
        bus3.req_valid = 4'b1111;
        #1;
        check("dr_g0", bus3.req_ready, 4'b1000);
        @(negedge clk);
        #1;
        check("dr_g1", bus3.req_ready, 4'b0001);
        @(negedge clk);
        en3 = 1'b0;
        #1;
        check("dr_g2", bus3.req_ready, 4'b0010);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            check("dr_nogrant", bus3.req_ready, 0);
            check("dr_rsp", bus3.rsp_valid, drain_exp[j]);
            check("dr_idle", idle3, 0);
            check("dr_busy", busy3, 1);
        end
        @(negedge clk);
        #1;
        check("dr_halt", idle3, 1);
        check("dr_busy0", busy3, 0);
        check("dr_rsp0", bus3.rsp_valid, 0);
        bus3.req_valid = 4'b0000;

        // Reset with two operations in flight
        @(negedge clk);
        en3 = 1'b1;
        @(negedge clk);
        bus3.req_valid = 4'b1111;
        #1;
        check("rf_g0", bus3.req_ready, 4'b0100);
        @(negedge clk);
        #1;
        check("rf_g1", bus3.req_ready, 4'b1000);
        @(negedge clk);
        bus3.req_valid = 4'b0000;
        en3 = 1'b0;
        rst = 1'b0;
        #1;
        check("rf_idle", idle3, 1);
        check("rf_busy", busy3, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("rf_norsp", bus3.rsp_valid, 0);
            check("rf_idle2", idle3, 1);
        end
        @(negedge clk);
        en3 = 1'b1;
        bus3.req_valid = 4'b1111;
        @(negedge clk);
        #1;
        check("rf_ptr0", bus3.req_ready, 4'b0001);
        @(negedge clk);
        bus3.req_valid = 4'b0000;
        en3 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
